// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: each cycle grants up to NUM_PORTS finished FU results to the CDB ports.
// Priority BEQ > MULT > LS > ALU, starving categories boosted first, round-robin inside a category.
module fu_wb_arbiter #(
  parameter int  NUM_PORTS    = 2,
  parameter int  NUM_ALU      = 8,
  parameter int  NUM_LS       = 4,
  parameter int  NUM_MULT     = 4,
  parameter int  NUM_BEQ      = 4,
  parameter int  STARVE_LIMIT = 4,
  localparam int NUM_FU       = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ,
  localparam int IDX_W        = $clog2(NUM_FU)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_result_valid,
  input  logic [NUM_PORTS-1:0]       cdb_ready,
  output logic [NUM_PORTS-1:0]       gnt_valid,
  output logic [NUM_PORTS*IDX_W-1:0] gnt_idx,
  output logic [NUM_PORTS*4-1:0]     gnt_cat,
  output logic [NUM_FU-1:0]          fu_ack,
  output logic [3:0]                 starve_boost
);

  localparam int MAX_AL  = (NUM_ALU > NUM_LS) ? NUM_ALU : NUM_LS;
  localparam int MAX_MB  = (NUM_MULT > NUM_BEQ) ? NUM_MULT : NUM_BEQ;
  localparam int MAX_CNT = (MAX_AL > MAX_MB) ? MAX_AL : MAX_MB;
  localparam int PTR_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int U_W     = PTR_W + 1;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam int PORT_W  = $clog2(NUM_PORTS + 1);

  // Category c: 0=ALU, 1=LS, 2=MULT, 3=BEQ; base priority grows with c.
  localparam int CAT_CNT  [4] = '{NUM_ALU, NUM_LS, NUM_MULT, NUM_BEQ};
  localparam int CAT_BASE [4] = '{0, NUM_ALU, NUM_ALU + NUM_LS, NUM_ALU + NUM_LS + NUM_MULT};

  logic [PTR_W-1:0] ptr_q    [4];
  logic [PTR_W-1:0] ptr_d    [4];
  logic [CNT_W-1:0] starve_q [4];
  logic [CNT_W-1:0] starve_d [4];
  logic [U_W-1:0]   last_unit [4];

  logic [3:0] boost;
  logic [3:0] cat_req;
  logic [3:0] cat_acked;

  logic [NUM_PORTS-1:0]       gnt_valid_c;
  logic [NUM_PORTS*IDX_W-1:0] gnt_idx_c;
  logic [NUM_PORTS*4-1:0]     gnt_cat_c;
  logic [NUM_FU-1:0]          ack_c;

  for (genvar g = 0; g < 4; g++) begin : g_req
    assign cat_req[g] = |fu_result_valid[CAT_BASE[g] +: CAT_CNT[g]];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      boost[c] = (starve_q[c] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Walk the ordered request list (boosted categories, then the rest, each BEQ..ALU and
  // starting at the category pointer) and hand each request to the next ready port.
  always_comb begin
    logic [U_W-1:0]    unit;
    logic [IDX_W-1:0]  fu;
    logic [PORT_W-1:0] next_port;
    logic              placed;
    // NOTE: every signal this block writes gets a default first, so no path leaves a
    // value held over and no latch is inferred.
    gnt_valid_c = '0;
    gnt_idx_c   = '0;
    gnt_cat_c   = '0;
    ack_c       = '0;
    cat_acked   = '0;
    unit        = '0;
    fu          = '0;
    next_port   = '0;
    placed      = 1'b0;
    for (int c = 0; c < 4; c++) begin
      last_unit[c] = '0;
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 3; c >= 0; c--) begin
        if (boost[c] == (pass == 0)) begin
          for (int j = 0; j < MAX_CNT; j++) begin
            if (j < CAT_CNT[c]) begin
              // NOTE: combinational scratch values use blocking '=' so later statements
              // in the same pass see the updated value.
              unit = U_W'(ptr_q[c]) + U_W'(j);
              if (unit >= U_W'(CAT_CNT[c])) unit = unit - U_W'(CAT_CNT[c]);
              fu = IDX_W'(CAT_BASE[c]) + IDX_W'(unit);
              if (fu_result_valid[fu]) begin
                placed = 1'b0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                  if (!placed && cdb_ready[p] && (PORT_W'(p) >= next_port)) begin
                    placed                      = 1'b1;
                    gnt_valid_c[p]              = 1'b1;
                    gnt_idx_c[p*IDX_W +: IDX_W] = fu;
                    gnt_cat_c[p*4 + c]          = 1'b1;
                    next_port                   = PORT_W'(p + 1);
                  end
                end
                if (placed) begin
                  ack_c[fu]     = 1'b1;
                  cat_acked[c]  = 1'b1;
                  last_unit[c]  = unit;
                end
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      ptr_d[c]    = ptr_q[c];
      starve_d[c] = starve_q[c];
      if (cat_acked[c]) begin
        if (last_unit[c] + U_W'(1) >= U_W'(CAT_CNT[c])) ptr_d[c] = '0;
        else                                             ptr_d[c] = PTR_W'(last_unit[c] + U_W'(1));
      end
      if (flush || cat_acked[c] || !cat_req[c]) starve_d[c] = '0;
      else if (!boost[c])                       starve_d[c] = starve_q[c] + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held, independent of the request inputs.
  always_comb begin
    gnt_valid = '0;
    gnt_idx   = '0;
    gnt_cat   = '0;
    fu_ack    = '0;
    if (reset) begin
      gnt_valid = gnt_valid_c;
      gnt_idx   = gnt_idx_c;
      gnt_cat   = gnt_cat_c;
      fu_ack    = ack_c;
    end
  end

  assign starve_boost = boost;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the pointer and counter arrays are a few flops, not a RAM, so they are
      // cleared by reset like any other state.
      for (int c = 0; c < 4; c++) begin
        ptr_q[c]    <= '0;
        starve_q[c] <= '0;
      end
    end else begin
      // NOTE: state registers update with non-blocking '<=' so every flop samples
      // the pre-edge values.
      for (int c = 0; c < 4; c++) begin
        ptr_q[c]    <= ptr_d[c];
        starve_q[c] <= starve_d[c];
      end
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter: a queue-based reference model checked every cycle
// on a default instance and a 3-port/6-ALU instance, plus hand-computed directed cases.
module tb_fu_wb_arbiter;

  localparam int LIMIT = 4;
  localparam int BOUND = 400;

  logic clk;
  logic rst_n;

  logic        flush_a, flush_b;
  logic [19:0] valid_a;
  logic [1:0]  ready_a;
  logic [1:0]  gv_a;
  logic [9:0]  gi_a;
  logic [7:0]  gc_a;
  logic [19:0] ack_a;
  logic [3:0]  sb_a;

  logic [17:0] valid_b;
  logic [2:0]  ready_b;
  logic [2:0]  gv_b;
  logic [14:0] gi_b;
  logic [11:0] gc_b;
  logic [17:0] ack_b;
  logic [3:0]  sb_b;

  fu_wb_arbiter dut_a (
    .clock(clk), .reset(rst_n), .flush(flush_a), .fu_result_valid(valid_a), .cdb_ready(ready_a),
    .gnt_valid(gv_a), .gnt_idx(gi_a), .gnt_cat(gc_a), .fu_ack(ack_a), .starve_boost(sb_a)
  );

  fu_wb_arbiter #(.NUM_PORTS(3), .NUM_ALU(6)) dut_b (
    .clock(clk), .reset(rst_n), .flush(flush_b), .fu_result_valid(valid_b), .cdb_ready(ready_b),
    .gnt_valid(gv_b), .gnt_idx(gi_b), .gnt_cat(gc_b), .fu_ack(ack_b), .starve_boost(sb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state, one row per instance.
  int m_cnt  [2][4];
  int m_base [2][4];
  int m_np   [2];
  int m_ptr  [2][4];
  int m_st   [2][4];
  int age    [2][20];
  logic [31:0] exp_ack [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build the ordered request list from the rules, then zip it with the ready ports.
  task automatic model_eval(input int i, input logic [31:0] v, input logic [3:0] rdy,
                            output logic [3:0] ev, output logic [19:0] ei,
                            output logic [15:0] ec, output logic [31:0] ea,
                            output logic [3:0] eb);
    int order[$];
    int cats[$];
    int k;
    int u;
    ev = '0; ei = '0; ec = '0; ea = '0; eb = '0;
    if (rst_n) begin
      for (int c = 0; c < 4; c++) eb[c] = (m_st[i][c] == LIMIT);
      for (int pass = 0; pass < 2; pass++) begin
        for (int c = 3; c >= 0; c--) begin
          if (eb[c] == (pass == 0)) begin
            for (int j = 0; j < m_cnt[i][c]; j++) begin
              u = (m_ptr[i][c] + j) % m_cnt[i][c];
              if (v[m_base[i][c] + u]) begin
                order.push_back(m_base[i][c] + u);
                cats.push_back(c);
              end
            end
          end
        end
      end
      k = 0;
      for (int p = 0; p < m_np[i]; p++) begin
        if (rdy[p] && k < order.size()) begin
          ev[p]         = 1'b1;
          ei[p*5 +: 5]  = 5'(order[k]);
          ec[p*4 + cats[k]] = 1'b1;
          ea[order[k]]  = 1'b1;
          k++;
        end
      end
    end
  endtask

  task automatic model_update(input int i, input logic [31:0] v, input logic [31:0] ack,
                              input logic fl);
    bit acked;
    bit req;
    int last;
    int u;
    for (int c = 0; c < 4; c++) begin
      acked = 1'b0;
      req   = 1'b0;
      last  = 0;
      for (int j = 0; j < m_cnt[i][c]; j++) begin
        u = (m_ptr[i][c] + j) % m_cnt[i][c];
        if (v[m_base[i][c] + u]) req = 1'b1;
        if (ack[m_base[i][c] + u]) begin
          acked = 1'b1;
          last  = u;
        end
      end
      if (!rst_n) begin
        m_ptr[i][c] = 0;
        m_st[i][c]  = 0;
      end else begin
        if (acked) m_ptr[i][c] = (last + 1) % m_cnt[i][c];
        if (fl || acked || !req) m_st[i][c] = 0;
        else if (m_st[i][c] < LIMIT) m_st[i][c]++;
      end
    end
  endtask

  // Compare both instances against the model mid-cycle, away from the clock edge.
  task automatic eval_cycle();
    logic [3:0]  ev, eb, av, ab, r;
    logic [19:0] ei, ai;
    logic [15:0] ec, ac;
    logic [31:0] ea, aa, v;
    int viol;
    bit dup;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        v = 32'(valid_a); r = 4'(ready_a); av = 4'(gv_a); ai = 20'(gi_a);
        ac = 16'(gc_a); aa = 32'(ack_a); ab = sb_a;
      end else begin
        v = 32'(valid_b); r = 4'(ready_b); av = 4'(gv_b); ai = 20'(gi_b);
        ac = 16'(gc_b); aa = 32'(ack_b); ab = sb_b;
      end
      model_eval(i, v, r, ev, ei, ec, ea, eb);
      exp_ack[i] = ea;
      check($sformatf("gnt_valid[%0d]", i), 32'(av), 32'(ev));
      check($sformatf("gnt_idx[%0d]", i), 32'(ai), 32'(ei));
      check($sformatf("gnt_cat[%0d]", i), 32'(ac), 32'(ec));
      check($sformatf("fu_ack[%0d]", i), aa, ea);
      check($sformatf("starve_boost[%0d]", i), 32'(ab), 32'(eb));
      viol = 0;
      for (int f = 0; f < 20; f++) if (age[i][f] > BOUND) viol++;
      check($sformatf("wait_bound[%0d]", i), 32'(viol), 32'd0);
    end
    dup = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int q = p + 1; q < 3; q++)
        if (gv_b[p] && gv_b[q] && gi_b[p*5 +: 5] == gi_b[q*5 +: 5]) dup = 1'b1;
    check("b_unique_grant", 32'(dup), 32'd0);
    check("b_ack_le_ready", 32'($countones(ack_b) <= $countones(ready_b)), 32'd1);
  endtask

  task automatic advance();
    logic [31:0] va, vb;
    @(posedge clk);
    va = 32'(valid_a);
    vb = 32'(valid_b);
    model_update(0, va, exp_ack[0], flush_a);
    model_update(1, vb, exp_ack[1], flush_b);
    for (int f = 0; f < 20; f++) begin
      if (!rst_n || !va[f] || exp_ack[0][f]) age[0][f] = 0; else age[0][f]++;
      if (!rst_n || !vb[f] || exp_ack[1][f]) age[1][f] = 0; else age[1][f]++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    valid_a = '0; ready_a = '0; valid_b = '0; ready_b = '0;
    eval_cycle();
    advance();
    rst_n = 1'b1;
  endtask

  initial begin
    m_cnt[0] = '{8, 4, 4, 4}; m_base[0] = '{0, 8, 12, 16}; m_np[0] = 2;
    m_cnt[1] = '{6, 4, 4, 4}; m_base[1] = '{0, 6, 10, 14}; m_np[1] = 3;
    for (int i = 0; i < 2; i++) begin
      exp_ack[i] = '0;
      for (int c = 0; c < 4; c++) begin m_ptr[i][c] = 0; m_st[i][c] = 0; end
      for (int f = 0; f < 20; f++) age[i][f] = 0;
    end
    rst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    valid_b = '0; ready_b = '0;

    // Reset held with every FU valid: nothing granted; release -> BEQ 16,17.
    valid_a = '1; ready_a = 2'b11;
    eval_cycle();
    check("t1_rst_gnt_valid", 32'(gv_a), 32'd0);
    check("t1_rst_fu_ack", 32'(ack_a), 32'd0);
    advance();
    rst_n = 1'b1;
    eval_cycle();
    check("t1_port0_idx", 32'(gi_a[4:0]), 32'd16);
    check("t1_port1_idx", 32'(gi_a[9:5]), 32'd17);
    check("t1_gnt_cat", 32'(gc_a), 32'h88);
    advance();

    // ALUs 0,3,5 held valid: {0,3}, {5,0}, {3,5}.
    do_reset();
    valid_a = 20'h00029; ready_a = 2'b11;
    for (int cyc = 0; cyc < 3; cyc++) begin
      logic [9:0] exp_pair;
      exp_pair = (cyc == 0) ? {5'd3, 5'd0} : (cyc == 1) ? {5'd0, 5'd5} : {5'd5, 5'd3};
      eval_cycle();
      check($sformatf("t2_rr_cycle%0d", cyc + 1), 32'(gi_a), 32'(exp_pair));
      advance();
    end

    // BEQ 16,17 and ALU 2 held: ALU starves 4 cycles, is boosted in cycle 5.
    do_reset();
    valid_a = 20'h30004; ready_a = 2'b11;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      eval_cycle();
      if (cyc <= 4) begin
        check("t3_boost_off", 32'(sb_a), 32'd0);
        check("t3_alu_waits", 32'(ack_a[2]), 32'd0);
      end else if (cyc == 5) begin
        check("t3_boost_alu", 32'(sb_a), 32'd1);
        check("t3_port0_alu", 32'(gi_a[4:0]), 32'd2);
        check("t3_port1_beq", 32'(gi_a[9:5]), 32'd16);
      end else begin
        check("t3_boost_cleared", 32'(sb_a), 32'd0);
      end
      advance();
    end

    // Only port 1 ready, FU12 and FU8 valid: MULT 12 on port 1, LS 8 waits.
    do_reset();
    valid_a = 20'h01100; ready_a = 2'b10;
    eval_cycle();
    check("t4_gnt_valid", 32'(gv_a), 32'd2);
    check("t4_port1_idx", 32'(gi_a[9:5]), 32'd12);
    check("t4_fu_ack", 32'(ack_a), 32'h01000);
    check("t4_gnt_cat", 32'(gc_a), 32'h40);
    advance();

    // Flush at counter 3 restarts the count: boost only after 4 more unserved cycles.
    do_reset();
    valid_a = 20'h30004; ready_a = 2'b11;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      flush_a = (cyc == 4);
      eval_cycle();
      if (cyc >= 5 && cyc <= 8) check("t5_no_boost", 32'(sb_a), 32'd0);
      if (cyc == 9) check("t5_boost_again", 32'(sb_a), 32'd1);
      advance();
    end
    flush_a = 1'b0;

    // Reset asserted mid-cycle drops outputs at once; first cycle after release is fresh.
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_gnt_valid", 32'(gv_a), 32'd0);
    check("t6_async_fu_ack", 32'(ack_a), 32'd0);
    check("t6_async_gnt_idx", 32'(gi_a), 32'd0);
    eval_cycle();
    advance();
    rst_n = 1'b1;
    eval_cycle();
    check("t6_fresh_port0", 32'(gi_a[4:0]), 32'd16);
    check("t6_fresh_port1", 32'(gi_a[9:5]), 32'd17);
    advance();

    // Random traffic on both instances; acked FUs drop valid for at least one cycle.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      valid_a = (valid_a | 20'($urandom & $urandom)) & ~exp_ack[0][19:0];
      valid_b = (valid_b | 18'($urandom & $urandom)) & ~exp_ack[1][17:0];
      ready_a = 2'($urandom | $urandom);
      ready_b = 3'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) ready_a = '0;
      if ($urandom_range(0, 15) == 0) ready_b = '0;
      flush_a = ($urandom_range(0, 63) == 0);
      flush_b = ($urandom_range(0, 63) == 0);
      eval_cycle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
